proximity_alert: RTL
====================

PROXIMITY_ALERT -- requirements
Module: proximity_alert

Interface
REQ-001 Parameter NEAR_CM, default 100, SHALL set the alert entry threshold in cm.
REQ-002 Parameter HYST_CM, default 10, SHALL set the alert exit hysteresis in cm.
REQ-003 Parameter STALE_MS, default 200, SHALL set the no-sample timeout in ms.
REQ-004 sys_clk  in  1  sole clock; all state SHALL be on its rising edge.
REQ-005 sys_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 tick_us  in  1  single-cycle strobe once per microsecond.
REQ-007 echo_valid  in  1  single-cycle strobe: new echo measurement present.
REQ-008 echo_width_us  in  16  echo high time in us, sampled when echo_valid=1.
REQ-009 echo_timeout  in  1  sampled with echo_valid; 1 = no echo received.
REQ-010 dist_cm  out  9  filtered distance, cm.
REQ-011 dist_valid  out  1  dist_cm holds a fresh filtered value.
REQ-012 near  out  1  obstacle-proximity flag with hysteresis.
REQ-013 alert_out  out  1  buzzer/haptic drive, beep pattern.

Function
REQ-014 Conversion SHALL compute raw = (echo_width_us * 1130) >> 16, 27-bit product, unsigned, truncating.
REQ-015 raw SHALL be clamped to MAX_CM = 400; echo_timeout=1 SHALL force raw = 400 regardless of width.
REQ-016 raw SHALL be registered 1 cycle after echo_valid (stage 1).
REQ-017 Filter: 4-entry history, 11-bit sum, dist_cm = sum >> 2, updated 2 cycles after echo_valid.
REQ-018 Priming: first sample after reset or after stale SHALL fill all 4 history entries with raw.
REQ-019 dist_valid SHALL rise with the first dist_cm update and stay 1 until stale or reset.
REQ-020 near SHALL be registered 3 cycles after echo_valid: set when dist_cm < NEAR_CM; cleared when dist_cm >= NEAR_CM + HYST_CM; otherwise held.
REQ-021 echo_valid on back-to-back cycles SHALL each be accepted; pipeline has no busy state.
REQ-022 ms counter: counts tick_us, wraps 999 -> 0, emitting a 1-cycle ms strobe.
REQ-023 Stale: ms count since last echo_valid reaching STALE_MS SHALL clear dist_valid, near, alert_out and re-arm priming; echo_valid resets the count.
REQ-024 Beep FSM states IDLE, ON, OFF, CONT.
REQ-025 IDLE -> ON when near=1 and dist_cm >= 20; IDLE -> CONT when near=1 and dist_cm < 20.
REQ-026 ON lasts 20 ms (alert_out=1), then OFF (alert_out=0) until total period = 2*dist_cm ms (period latched at ON entry, min 40 ms), then ON again.
REQ-027 CONT: alert_out=1 continuously while dist_cm < 20; dist_cm >= 20 -> OFF (alert_out=0), then ON at next period boundary.
REQ-028 near=0 in any state -> IDLE, alert_out=0, next cycle.
REQ-029 tick_us and echo_valid on the same cycle SHALL both take effect.

Reset
REQ-030 Reset SHALL asynchronously clear all registers: dist_cm=0, dist_valid=0, near=0, alert_out=0, FSM=IDLE, history empty, priming armed.
REQ-031 Reset asserted mid-beep or mid-pipeline SHALL drop all outputs to 0 without waiting for a clock.

Structure
REQ-032 Shared package helmet_pkg SHALL hold MAX_CM=400, RECIP_58=1130, DIST_W=9, and the beep state enum.
REQ-033 Beep FSM plus ms counter SHALL be one sub-module beep_timer; conversion, filter and hysteresis stay in the top.

Verification
REQ-034 Reset, one sample width 2900 -> dist_cm=50, dist_valid=1 two cycles later; near=1 one cycle after that.
REQ-035 Four samples 5800 then one 2900 -> dist_cm=100, then 87.
REQ-036 Filtered 95 -> near=1; 105 -> near stays 1; 110 -> near=0.
REQ-037 Four samples with echo_timeout=1 -> dist_cm=400, near=0, alert_out=0.
REQ-038 Steady dist 50 -> alert_out 20 ms high / 80 ms low; width 870 (dist 15) -> alert_out continuously 1.
REQ-039 No echo_valid for 200 ms -> dist_valid=0, alert_out=0; next sample 2320 -> dist_cm=40 (re-primed).

Source files
------------

// File: rtl/helmet_pkg.sv
// -----------------------------------------------------------------------------
// helmet_pkg
//   Shared constants, the beep state encoding and the echo-to-distance helper
//   used by the proximity alert top and its beep timer.
// -----------------------------------------------------------------------------
package helmet_pkg;

    localparam int unsigned DIST_W   = 9;                  // distance width, cm
    localparam int unsigned SUM_W    = DIST_W + 2;         // 4-entry history sum
    localparam int unsigned PERIOD_W = DIST_W + 1;         // beep period, ms

    localparam logic [DIST_W-1:0] MAX_CM   = 9'd400;       // sensor range limit
    localparam logic [10:0]       RECIP_58 = 11'd1130;     // 65536 / 58 (us -> cm)

    localparam logic [DIST_W-1:0]   CONT_CM       = 9'd20; // continuous-tone limit
    localparam logic [PERIOD_W-1:0] BEEP_ON_MS    = 10'd20;
    localparam logic [PERIOD_W-1:0] MIN_PERIOD_MS = 10'd40;

    typedef enum logic [1:0] {
        BEEP_IDLE,
        BEEP_ON,
        BEEP_OFF,
        BEEP_CONT
    } beep_state_e;

    // Echo high time (us) to distance (cm): width * 1130 in a 27-bit product,
    // upper 11 bits kept, then clamped to the sensor range. A timed-out echo
    // reads as "nothing in range".
    function automatic logic [DIST_W-1:0] echo_to_cm(input logic [15:0] width_us,
                                                     input logic        timeout);
        logic [10:0] raw;
        raw = 11'(({11'b0, width_us} * {16'b0, RECIP_58}) >> 16);
        if (timeout || (raw > {2'b00, MAX_CM})) begin
            return MAX_CM;
        end
        return raw[DIST_W-1:0];
    endfunction

endpackage

// File: rtl/beep_timer.sv
// -----------------------------------------------------------------------------
// beep_timer
//   Millisecond prescaler and the buzzer pattern FSM. The beep period follows
//   the obstacle distance (2 ms per cm, floor 40 ms, 20 ms on-time); very close
//   obstacles give a continuous tone.
//
//   sys_clk    in   clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   tick_us    in   1-cycle strobe per microsecond
//   near       in   proximity flag; 0 silences the buzzer
//   clear      in   stale-data override, forces IDLE
//   dist_cm    in   filtered distance, cm
//   ms_tick    out  1-cycle strobe per millisecond (combinational)
//   alert_out  out  registered buzzer drive
// -----------------------------------------------------------------------------
module beep_timer
    import helmet_pkg::*;
#(
    parameter int unsigned TICKS_PER_MS = 1000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              tick_us,
    input  logic              near,
    input  logic              clear,
    input  logic [DIST_W-1:0] dist_cm,
    output logic              ms_tick,
    output logic              alert_out
);

    localparam int unsigned US_W        = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int unsigned US_LAST_INT = TICKS_PER_MS - 1;
    localparam logic [US_W-1:0] US_LAST = US_LAST_INT[US_W-1:0];

    logic [US_W-1:0]     us_cnt_q,  us_cnt_d;
    beep_state_e         state_q,   state_d;
    logic [PERIOD_W-1:0] elapsed_q, elapsed_d;   // ms since the last ON entry
    logic [PERIOD_W-1:0] period_q,  period_d;    // period latched at ON entry
    logic                alert_q,   alert_d;

    logic [PERIOD_W-1:0] elapsed_inc;
    logic [PERIOD_W-1:0] period_now;
    logic                dist_close;

    always_comb begin
        us_cnt_d = us_cnt_q;
        ms_tick  = 1'b0;
        if (tick_us) begin
            if (us_cnt_q == US_LAST) begin
                us_cnt_d = '0;
                ms_tick  = 1'b1;
            end else begin
                us_cnt_d = us_cnt_q + 1'b1;
            end
        end
    end

    assign elapsed_inc = elapsed_q + 1'b1;
    assign period_now  = ({dist_cm, 1'b0} < MIN_PERIOD_MS) ? MIN_PERIOD_MS
                                                           : {dist_cm, 1'b0};
    assign dist_close  = (dist_cm < CONT_CM);

    always_comb begin
        state_d   = state_q;
        elapsed_d = elapsed_q;
        period_d  = period_q;

        case (state_q)
            BEEP_IDLE: begin
                if (near) begin
                    elapsed_d = '0;
                    if (dist_close) begin
                        state_d  = BEEP_CONT;
                        period_d = MIN_PERIOD_MS;
                    end else begin
                        state_d  = BEEP_ON;
                        period_d = period_now;
                    end
                end
            end

            BEEP_ON: begin
                if (ms_tick) begin
                    elapsed_d = elapsed_inc;
                    if (elapsed_inc == BEEP_ON_MS) begin
                        state_d = BEEP_OFF;
                    end
                end
            end

            BEEP_OFF: begin
                if (ms_tick) begin
                    if (elapsed_inc >= period_q) begin
                        // Period boundary: re-decide between beeping and a
                        // continuous tone from the current distance.
                        elapsed_d = '0;
                        if (dist_close) begin
                            state_d  = BEEP_CONT;
                            period_d = MIN_PERIOD_MS;
                        end else begin
                            state_d  = BEEP_ON;
                            period_d = period_now;
                        end
                    end else begin
                        elapsed_d = elapsed_inc;
                    end
                end
            end

            BEEP_CONT: begin
                // Keep the period phase running so that leaving CONT resumes
                // beeping on a period boundary rather than immediately.
                if (ms_tick) begin
                    elapsed_d = (elapsed_inc >= period_q) ? '0 : elapsed_inc;
                end
                if (!dist_close) begin
                    state_d = BEEP_OFF;
                end
            end

            default: state_d = BEEP_IDLE;
        endcase

        if (!near || clear) begin
            state_d = BEEP_IDLE;
        end

        alert_d = (state_d == BEEP_ON) || (state_d == BEEP_CONT);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            us_cnt_q  <= '0;
            state_q   <= BEEP_IDLE;
            elapsed_q <= '0;
            period_q  <= MIN_PERIOD_MS;
            alert_q   <= 1'b0;
        end else begin
            us_cnt_q  <= us_cnt_d;
            state_q   <= state_d;
            elapsed_q <= elapsed_d;
            period_q  <= period_d;
            alert_q   <= alert_d;
        end
    end

    assign alert_out = alert_q;

endmodule

// File: rtl/proximity_alert.sv
// -----------------------------------------------------------------------------
// proximity_alert
//   Ultrasonic echo to filtered distance, proximity flag with hysteresis and a
//   distance-dependent buzzer pattern. Pipeline: echo -> raw cm (1 cycle) ->
//   4-sample moving average (1 cycle) -> near flag (1 cycle). Data older than
//   STALE_MS invalidates the outputs and re-primes the filter.
//
//   sys_clk        in   clock, rising edge
//   sys_rst_n      in   asynchronous active-low reset
//   tick_us        in   1-cycle strobe per microsecond
//   echo_valid     in   1-cycle strobe: new measurement
//   echo_width_us  in   echo high time, us
//   echo_timeout   in   1 = no echo received
//   dist_cm        out  filtered distance, cm
//   dist_valid     out  dist_cm is fresh
//   near           out  obstacle-proximity flag
//   alert_out      out  buzzer drive
//
//   TICKS_PER_MS sets how many tick_us strobes make one millisecond.
// -----------------------------------------------------------------------------
module proximity_alert
    import helmet_pkg::*;
#(
    parameter int unsigned NEAR_CM      = 100,
    parameter int unsigned HYST_CM      = 10,
    parameter int unsigned STALE_MS     = 200,
    parameter int unsigned TICKS_PER_MS = 1000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              tick_us,
    input  logic              echo_valid,
    input  logic [15:0]       echo_width_us,
    input  logic              echo_timeout,
    output logic [DIST_W-1:0] dist_cm,
    output logic              dist_valid,
    output logic              near,
    output logic              alert_out
);

    localparam int unsigned EXIT_CM = NEAR_CM + HYST_CM;
    localparam logic [DIST_W:0] NEAR_TH = NEAR_CM[DIST_W:0];
    localparam logic [DIST_W:0] EXIT_TH = EXIT_CM[DIST_W:0];

    localparam int unsigned STALE_W = $clog2(STALE_MS + 1);
    localparam logic [STALE_W-1:0] STALE_LIM = STALE_MS[STALE_W-1:0];

    // Stage 1: converted sample.
    logic [DIST_W-1:0]  raw_q,       raw_d;
    logic               raw_valid_q, raw_valid_d;

    // Stage 2: moving-average history (circular, ptr_q marks the oldest).
    logic [DIST_W-1:0]  hist_q [4];
    logic [DIST_W-1:0]  hist_d [4];
    logic [SUM_W-1:0]   sum_q,       sum_d;
    logic [1:0]         ptr_q,       ptr_d;
    logic               prime_q,     prime_d;
    logic [DIST_W-1:0]  dist_cm_q,   dist_cm_d;
    logic               dist_valid_q, dist_valid_d;

    // Stage 3 and staleness.
    logic               near_q,      near_d;
    logic [STALE_W-1:0] stale_cnt_q, stale_cnt_d;
    logic               stale;
    logic               ms_tick;

    assign stale = (stale_cnt_q == STALE_LIM);

    // NOTE: every signal gets its default before any branch so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        raw_d        = raw_q;
        raw_valid_d  = echo_valid;
        hist_d       = hist_q;
        sum_d        = sum_q;
        ptr_d        = ptr_q;
        prime_d      = prime_q;
        dist_cm_d    = dist_cm_q;
        dist_valid_d = dist_valid_q;
        near_d       = near_q;
        stale_cnt_d  = stale_cnt_q;

        if (echo_valid) begin
            raw_d = echo_to_cm(echo_width_us, echo_timeout);
        end

        if (raw_valid_q) begin
            if (prime_q) begin
                // First sample after reset or stale fills the whole history so
                // the average starts at the measured value, not at zero.
                hist_d  = '{default: raw_q};
                sum_d   = {raw_q, 2'b00};
                ptr_d   = 2'd0;
                prime_d = 1'b0;
            end else begin
                hist_d[ptr_q] = raw_q;
                sum_d         = sum_q - {2'b00, hist_q[ptr_q]} + {2'b00, raw_q};
                ptr_d         = ptr_q + 2'd1;
            end
            dist_cm_d    = sum_d[SUM_W-1:2];
            dist_valid_d = 1'b1;
        end

        // Hysteresis band [NEAR_CM, NEAR_CM + HYST_CM) holds the last decision.
        if ({1'b0, dist_cm_q} < NEAR_TH) begin
            near_d = 1'b1;
        end else if ({1'b0, dist_cm_q} >= EXIT_TH) begin
            near_d = 1'b0;
        end
        if (!dist_valid_q) begin
            near_d = 1'b0;
        end

        if (echo_valid) begin
            stale_cnt_d = '0;
        end else if (ms_tick && !stale) begin
            stale_cnt_d = stale_cnt_q + 1'b1;
        end

        if (stale) begin
            dist_valid_d = 1'b0;
            near_d       = 1'b0;
            prime_d      = 1'b1;
        end
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values
    // regardless of the order the statements appear in.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            raw_q        <= '0;
            raw_valid_q  <= 1'b0;
            // NOTE: the history is a four-entry register array, not a RAM, so
            // it is reset along with the other flops.
            hist_q       <= '{default: '0};
            sum_q        <= '0;
            ptr_q        <= 2'd0;
            prime_q      <= 1'b1;
            dist_cm_q    <= '0;
            dist_valid_q <= 1'b0;
            near_q       <= 1'b0;
            stale_cnt_q  <= '0;
        end else begin
            raw_q        <= raw_d;
            raw_valid_q  <= raw_valid_d;
            hist_q       <= hist_d;
            sum_q        <= sum_d;
            ptr_q        <= ptr_d;
            prime_q      <= prime_d;
            dist_cm_q    <= dist_cm_d;
            dist_valid_q <= dist_valid_d;
            near_q       <= near_d;
            stale_cnt_q  <= stale_cnt_d;
        end
    end

    beep_timer #(
        .TICKS_PER_MS (TICKS_PER_MS)
    ) u_beep_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tick_us   (tick_us),
        .near      (near_q),
        .clear     (stale),
        .dist_cm   (dist_cm_q),
        .ms_tick   (ms_tick),
        .alert_out (alert_out)
    );

    assign dist_cm    = dist_cm_q;
    assign dist_valid = dist_valid_q;
    assign near       = near_q;

endmodule
